// File: rtl/bf16_pkg.sv
// Shared bf16 definitions for the bf16 <-> fixed-point converters.
// Holds format constants, the packed bf16 layout and the operand class enum.
package bf16_pkg;

  localparam int unsigned BF16_BIAS    = 127;
  localparam int unsigned BF16_EXP_W   = 8;
  localparam int unsigned BF16_MANT_W  = 7;
  localparam int unsigned BF16_EXP_MAX = 255;
  localparam int unsigned BF16_SIG_W   = BF16_MANT_W + 1;
  localparam int unsigned BF16_SH_W    = 10;

  typedef struct packed {
    logic                   sign;
    logic [BF16_EXP_W-1:0]  exp;
    logic [BF16_MANT_W-1:0] mant;
  } bf16_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN,
    CLS_OVF
  } bf16_class_e;

endpackage

// File: rtl/bf16_round_sat.sv
// Combinational round / saturate / negate datapath for the bf16 -> fixed converter.
// Ports:
//   cls_i  : operand class from the decode stage
//   sign_i : operand sign
//   sig_i  : significand {1, mant}
//   sh_i   : signed left-shift amount that aligns sig_i to the output LSB
//   data_o : two's-complement fixed-point result (OUT_W bits)
//   sat_o  : result was clamped
//   nan_o  : operand was NaN (data_o is 0)
module bf16_round_sat
  import bf16_pkg::*;
#(
  parameter int unsigned OUT_W = 18
) (
  input  bf16_class_e                   cls_i,
  input  logic                          sign_i,
  input  logic [BF16_SIG_W-1:0]         sig_i,
  input  logic signed [BF16_SH_W-1:0]   sh_i,
  output logic [OUT_W-1:0]              data_o,
  output logic                          sat_o,
  output logic                          nan_o
);

  localparam int unsigned MAG_W = OUT_W + 1;
  localparam logic [MAG_W-1:0] POS_LIM   = MAG_W'(2 ** (OUT_W - 1) - 1);
  localparam logic [MAG_W-1:0] NEG_LIM   = MAG_W'(2 ** (OUT_W - 1));
  localparam logic [OUT_W-1:0] POS_CLAMP = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_CLAMP = {1'b1, {(OUT_W - 1){1'b0}}};

  logic [MAG_W-1:0]        mag;
  logic [3:0]              rsh;
  logic [2*BF16_SIG_W-1:0] shifted;
  logic                    round_up;

  // Magnitude: left shift, or right shift with round-to-nearest-even.
  // sig is placed above an 8-bit fraction so guard/sticky fall out of one shift.
  always_comb begin
    mag      = '0;
    rsh      = '0;
    shifted  = '0;
    round_up = 1'b0;
    if (!sh_i[BF16_SH_W-1]) begin
      mag = MAG_W'(sig_i) << $unsigned(sh_i);
    end else if (sh_i >= -10'sd9) begin
      rsh      = 4'(-sh_i);
      shifted  = {sig_i, {BF16_SIG_W{1'b0}}} >> rsh;
      round_up = shifted[BF16_SIG_W-1] &&
                 ((|shifted[BF16_SIG_W-2:0]) || shifted[BF16_SIG_W]);
      mag      = MAG_W'(shifted[2*BF16_SIG_W-1:BF16_SIG_W]) + MAG_W'(round_up);
    end
  end

  // Class handling; saturation is judged on the magnitude before negation.
  always_comb begin
    data_o = '0;
    sat_o  = 1'b0;
    nan_o  = 1'b0;
    case (cls_i)
      CLS_NAN: nan_o = 1'b1;
      CLS_INF, CLS_OVF: begin
        sat_o  = 1'b1;
        data_o = sign_i ? NEG_CLAMP : POS_CLAMP;
      end
      CLS_NORMAL: begin
        if (sign_i) begin
          if (mag > NEG_LIM) begin
            sat_o  = 1'b1;
            data_o = NEG_CLAMP;
          end else begin
            data_o = OUT_W'(0) - mag[OUT_W-1:0];
          end
        end else begin
          if (mag > POS_LIM) begin
            sat_o  = 1'b1;
            data_o = POS_CLAMP;
          end else begin
            data_o = mag[OUT_W-1:0];
          end
        end
      end
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/bf16_to_fixed_stream.sv
// Two-stage streaming bf16 -> signed fixed-point Q(OUT_W-FRAC_BITS).FRAC_BITS converter.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake, in_bf16 is the operand
//   out_valid/out_ready   : output handshake
//   out_data/out_sat/out_nan : registered result and flags
//   clr_stats             : synchronous clear of sat_count (wins over increment)
//   sat_count             : saturating count of transferred outputs with out_sat=1
module bf16_to_fixed_stream
  import bf16_pkg::*;
#(
  parameter int unsigned OUT_W     = 18,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_bf16,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_nan,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sat_count
);

  // Offset turning a biased exponent into the left shift of {1,mant}.
  localparam logic signed [BF16_SH_W-1:0] SH_OFS =
    BF16_SH_W'(FRAC_BITS) - BF16_SH_W'(BF16_BIAS + BF16_MANT_W);
  localparam logic signed [BF16_SH_W-1:0] SH_OVF = BF16_SH_W'(OUT_W - 8);

  bf16_t                        in_w;
  bf16_class_e                  cls_d, cls_q;
  logic signed [BF16_SH_W-1:0]  sh_d, sh_q;
  logic [BF16_SIG_W-1:0]        sig_d, sig_q;
  logic                         sign_q;
  logic                         s1_valid_q;
  logic                         s1_move, s1_load;

  logic                         out_valid_q, out_sat_q, out_nan_q;
  logic [OUT_W-1:0]             out_data_q;
  logic [OUT_W-1:0]             rs_data;
  logic                         rs_sat, rs_nan;
  logic [CNT_W-1:0]             sat_cnt_q;

  assign in_w     = bf16_t'(in_bf16);
  assign s1_move  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_move;
  assign s1_load  = in_valid && in_ready;

  // S1 decode: classify the operand and compute the alignment shift.
  always_comb begin
    sig_d = {1'b1, in_w.mant};
    sh_d  = $signed({2'b00, in_w.exp}) + SH_OFS;
    cls_d = CLS_NORMAL;
    if (in_w.exp == '0) begin
      cls_d = CLS_ZERO;
    end else if (in_w.exp == BF16_EXP_W'(BF16_EXP_MAX)) begin
      cls_d = (in_w.mant != '0) ? CLS_NAN : CLS_INF;
    end else if (sh_d > SH_OVF) begin
      cls_d = CLS_OVF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      cls_q      <= CLS_ZERO;
      sign_q     <= 1'b0;
      sig_q      <= '0;
      sh_q       <= '0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      cls_q      <= cls_d;
      sign_q     <= in_w.sign;
      sig_q      <= sig_d;
      sh_q       <= sh_d;
    end else if (s1_move) begin
      s1_valid_q <= 1'b0;
    end
  end

  bf16_round_sat #(
    .OUT_W (OUT_W)
  ) u_round_sat (
    .cls_i  (cls_q),
    .sign_i (sign_q),
    .sig_i  (sig_q),
    .sh_i   (sh_q),
    .data_o (rs_data),
    .sat_o  (rs_sat),
    .nan_o  (rs_nan)
  );

  // S2 output register: loads when S1 advances, empties on a downstream accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_nan_q   <= 1'b0;
    end else if (s1_move) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rs_data;
      out_sat_q   <= rs_sat;
      out_nan_q   <= rs_nan;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturation statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (clr_stats) begin
      sat_cnt_q <= '0;
    end else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_nan   = out_nan_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_bf16_to_fixed_stream.sv
// Scoreboard bench for bf16_to_fixed_stream: directed vectors with hand-computed results.
module tb_bf16_to_fixed_stream;

  localparam int unsigned OUT_W = 18;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_bf16 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_nan;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] sat_count;

  bf16_to_fixed_stream #(
    .OUT_W     (18),
    .FRAC_BITS (8),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bf16   (in_bf16),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_nan   (out_nan),
    .clr_stats (clr_stats),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
    logic             nan;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   accepted = 0;

  function automatic exp_t ex(input logic [OUT_W-1:0] d, input logic s, input logic n);
    ex = '{data: d, sat: s, nan: n};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compare each transferred output against the scoreboard, and
  // check the output holds steady across stalled cycles.
  logic stall_prev = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && stall_prev)
        chk("hold_stable", 32'({out_data, out_sat, out_nan}), 32'(held));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = sb_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_sat", 32'(out_sat), 32'(e.sat));
          chk("out_nan", 32'(out_nan), 32'(e.nan));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = ex(out_data, out_sat, out_nan);
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Offer one beat (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic [15:0] v, input exp_t e);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_bf16  = v;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        accepted++;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      budget++;
      if (budget > 50) begin
        fail_now("send_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int min_acc);
    int budget;
    budget = 0;
    while ((sb_q.size() > 0 || accepted < min_acc) && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 100) begin
      fail_now("drain_timeout");
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_out_nan", 32'(out_nan), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: 1.0 -> 0x00100, out_valid two cycles after being offered.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bf16   = 16'h3F80;
    sb_q.push_back(ex(18'h00100, 1'b0, 1'b0));
    @(negedge clk);
    chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Exact values and rounding.
    send(16'hC040, ex(18'h3FD00, 1'b0, 1'b0));
    send(16'h3B80, ex(18'h00001, 1'b0, 1'b0));
    send(16'h3B00, ex(18'h00000, 1'b0, 1'b0));
    send(16'h3B40, ex(18'h00001, 1'b0, 1'b0));
    send(16'h3BC0, ex(18'h00002, 1'b0, 1'b0));
    send(16'h0001, ex(18'h00000, 1'b0, 1'b0));
    send(16'h8000, ex(18'h00000, 1'b0, 1'b0));
    send(16'hBB80, ex(18'h3FFFF, 1'b0, 1'b0));
    drain(0);
    chk("sat_count_exact", 32'(sat_count), 32'd0);

    // Saturation boundaries.
    send(16'h4400, ex(18'h1FFFF, 1'b1, 1'b0));
    send(16'hC400, ex(18'h20000, 1'b0, 1'b0));
    send(16'h7F80, ex(18'h1FFFF, 1'b1, 1'b0));
    send(16'hFF80, ex(18'h20000, 1'b1, 1'b0));
    drain(0);
    chk("sat_count_after_sat", 32'(sat_count), 32'd3);

    // NaN.
    send(16'h7FC0, ex(18'h00000, 1'b0, 1'b1));
    drain(0);
    chk("sat_count_after_nan", 32'(sat_count), 32'd3);

    // Backpressure: 5 beats offered with downstream stalled for 6 cycles.
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        send(16'h3F80, ex(18'h00100, 1'b0, 1'b0));
        send(16'h4000, ex(18'h00200, 1'b0, 1'b0));
        send(16'hC000, ex(18'h3FE00, 1'b0, 1'b0));
        send(16'h3F00, ex(18'h00080, 1'b0, 1'b0));
        send(16'h4040, ex(18'h00300, 1'b0, 1'b0));
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    chk("bp_accepted", 32'(accepted), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    drain(5);
    wait fork;
    chk("bp_total_accepted", 32'(accepted), 32'd5);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(16'h3F80, ex(18'h00100, 1'b0, 1'b0));
    send(16'h4400, ex(18'h1FFFF, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sat_count", 32'(sat_count), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // clr_stats coincident with a saturating output transfer.
    send(16'h4400, ex(18'h1FFFF, 1'b1, 1'b0));
    drain(0);
    chk("sat_count_one", 32'(sat_count), 32'd1);
    out_ready = 1'b0;
    send(16'hC800, ex(18'h20000, 1'b1, 1'b0));
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 20) fail_now("clr_wait_timeout");
    out_ready = 1'b1;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    chk("clr_sat_count", 32'(sat_count), 32'd0);
    chk("clr_consumed", 32'(sb_q.size()), 32'd0);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
